sc_lane_scheduler: RTL and testbench

SC_LANE_SCHEDULER -- requirements
Module: sc_lane_scheduler

---
 rtl/sc_lane_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_sc_lane_scheduler.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sc_lane_scheduler.sv
// sc_lane_scheduler
// Schedules shifts for LANES background lane shift registers. Each lane has a
// tick-driven countdown reloaded from its speed field; when a countdown expires
// the lane becomes pending and is dispatched (one shift command) by the FSM,
// lowest-index pending lane first, at most one shift every two cycles.
// Optional feature macro: SC_LANE_SCHEDULER_PAUSE_EN (freezes counters, pending
// bits and dispatch while pause is held low in RUN).
module sc_lane_scheduler #(
    parameter int                LANES    = 4,
    parameter int                SPEED_W  = 4,
    parameter logic [LANES-1:0]  DIR_MASK = 4'b0101
) (
    input  logic                       SC_LANE_SCHEDULER_CLOCK_50,
    input  logic                       SC_LANE_SCHEDULER_RESET_InLow,
    input  logic                       SC_LANE_SCHEDULER_startButton_InLow,
    input  logic                       SC_LANE_SCHEDULER_tick_InLow,
    input  logic                       SC_LANE_SCHEDULER_pause_InLow,
    input  logic [LANES*SPEED_W-1:0]   SC_LANE_SCHEDULER_speed_In,
    output logic                       SC_LANE_SCHEDULER_clear_OutLow,
    output logic                       SC_LANE_SCHEDULER_load_OutLow,
    output logic [LANES-1:0]           SC_LANE_SCHEDULER_laneSelect_Out,
    output logic [1:0]                 SC_LANE_SCHEDULER_shiftselection_Out,
    output logic                       SC_LANE_SCHEDULER_overrun_OutLow
);

    localparam int GRANT_W = (LANES > 1) ? $clog2(LANES) : 1;

    localparam logic [2:0] ST_RESET    = 3'd0;
    localparam logic [2:0] ST_IDLE     = 3'd1;
    localparam logic [2:0] ST_INIT     = 3'd2;
    localparam logic [2:0] ST_LOAD     = 3'd3;
    localparam logic [2:0] ST_WAIT_REL = 3'd4;
    localparam logic [2:0] ST_RUN      = 3'd5;
    localparam logic [2:0] ST_DISPATCH = 3'd6;

    localparam logic [1:0] SHIFT_HOLD  = 2'b11;
    localparam logic [1:0] SHIFT_RIGHT = 2'b10;
    localparam logic [1:0] SHIFT_LEFT  = 2'b01;

    logic [2:0]         stateReg, stateNext;
    logic [LANES-1:0]   pendingReg, pendingNext;
    logic [GRANT_W-1:0] grantReg, grantNext;
    logic               overrunReg, overrunNext;

    logic               startReq;
    logic               tickReq;
    logic               pauseHold;
    logic               tickCount;
    logic               inInit;
    logic               inDispatch;
    logic [LANES-1:0]   laneSet;
    logic [LANES-1:0]   grantOneHot;
    logic [LANES-1:0]   dispatchClear;
    logic [GRANT_W-1:0] lowestIdx;
    logic               overrunHit;

    assign startReq   = !SC_LANE_SCHEDULER_startButton_InLow;
    assign tickReq    = !SC_LANE_SCHEDULER_tick_InLow;
    assign inInit     = (stateReg == ST_INIT);
    assign inDispatch = (stateReg == ST_DISPATCH);

`ifdef SC_LANE_SCHEDULER_PAUSE_EN
    // Pause only has meaning in RUN; a dispatch already in flight completes.
    assign pauseHold = !SC_LANE_SCHEDULER_pause_InLow && (stateReg == ST_RUN);
`else
    logic unusedPause;
    assign unusedPause = SC_LANE_SCHEDULER_pause_InLow;
    assign pauseHold   = 1'b0;
`endif

    // Ticks are counted in both RUN and DISPATCH so a dispatch never drops a tick.
    assign tickCount = tickReq && (((stateReg == ST_RUN) && !pauseHold) || inDispatch);

    // ------------------------------------------------------------------
    // Per-lane countdown. A zero counter means the lane is disabled: it was
    // reloaded with speed 0, so it holds and never raises pending. A new
    // speed value is only picked up when the counter reloads.
    // ------------------------------------------------------------------
    for (genvar gi = 0; gi < LANES; gi++) begin : gLane
        logic [SPEED_W-1:0] speedLane;
        logic [SPEED_W-1:0] counterReg, counterNext;
        logic               laneActive;

        assign speedLane  = SC_LANE_SCHEDULER_speed_In[gi*SPEED_W +: SPEED_W];
        assign laneActive = tickCount && (counterReg != '0);
        assign laneSet[gi] = laneActive && (counterReg == SPEED_W'(1));

        assign counterNext = inInit      ? speedLane :
                             laneSet[gi] ? speedLane :
                             laneActive  ? (counterReg - SPEED_W'(1)) :
                                           counterReg;

        // Lane countdown register.
        always_ff @(posedge SC_LANE_SCHEDULER_CLOCK_50 or negedge SC_LANE_SCHEDULER_RESET_InLow) begin
            if (!SC_LANE_SCHEDULER_RESET_InLow) begin
                counterReg <= '0;
            end else begin
                counterReg <= counterNext;
            end
        end

        assign grantOneHot[gi] = (grantReg == GRANT_W'(gi));
    end

    assign dispatchClear = inDispatch ? grantOneHot : '0;

    // A new expiry on an already pending lane is an overrun, unless that lane
    // is being dispatched in the same cycle (the shift consumes the old one).
    assign overrunHit  = |(laneSet & pendingReg & ~dispatchClear);

    assign pendingNext = inInit ? '0 : ((pendingReg & ~dispatchClear) | laneSet);
    assign overrunNext = inInit ? 1'b1 : (overrunReg & ~overrunHit);

    // Lowest-index pending lane has priority for the next dispatch.
    always_comb begin
        lowestIdx = '0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (pendingReg[i]) begin
                lowestIdx = GRANT_W'(i);
            end
        end
    end

    // Sequencer next-state and grant latch.
    always_comb begin
        stateNext = stateReg;
        grantNext = grantReg;
        case (stateReg)
            ST_RESET: begin
                stateNext = ST_IDLE;
            end
            ST_IDLE: begin
                if (startReq) begin
                    stateNext = ST_INIT;
                end
            end
            ST_INIT: begin
                stateNext = ST_LOAD;
            end
            ST_LOAD: begin
                stateNext = ST_WAIT_REL;
            end
            ST_WAIT_REL: begin
                if (!startReq) begin
                    stateNext = ST_RUN;
                end
            end
            ST_RUN: begin
                if (startReq) begin
                    stateNext = ST_INIT;
                end else if (pauseHold) begin
                    stateNext = ST_RUN;
                end else if (|pendingReg) begin
                    stateNext = ST_DISPATCH;
                    grantNext = lowestIdx;
                end
            end
            ST_DISPATCH: begin
                // A restart request is honoured from RUN after the shift completes.
                stateNext = ST_RUN;
            end
            default: begin
                stateNext = ST_RESET;
            end
        endcase
    end

    // Sequencer state, pending set, grant and sticky overrun flag.
    always_ff @(posedge SC_LANE_SCHEDULER_CLOCK_50 or negedge SC_LANE_SCHEDULER_RESET_InLow) begin
        if (!SC_LANE_SCHEDULER_RESET_InLow) begin
            stateReg   <= ST_RESET;
            pendingReg <= '0;
            grantReg   <= '0;
            overrunReg <= 1'b1;
        end else begin
            stateReg   <= stateNext;
            pendingReg <= pendingNext;
            grantReg   <= grantNext;
            overrunReg <= overrunNext;
        end
    end

    // Outputs decode only registered state, so reset forces them immediately.
    assign SC_LANE_SCHEDULER_clear_OutLow   = !((stateReg == ST_RESET) || inInit);
    assign SC_LANE_SCHEDULER_load_OutLow    = !(stateReg == ST_LOAD);
    assign SC_LANE_SCHEDULER_overrun_OutLow = overrunReg;
    assign SC_LANE_SCHEDULER_laneSelect_Out = inDispatch ? grantOneHot : '0;
    assign SC_LANE_SCHEDULER_shiftselection_Out =
        !inDispatch         ? SHIFT_HOLD :
        DIR_MASK[grantReg]  ? SHIFT_LEFT : SHIFT_RIGHT;

endmodule

// File: tb/tb_sc_lane_scheduler.sv
// Scoreboard bench for sc_lane_scheduler: stimulus pushes expected events
// (clear pulse, load pulse, lane shift) with the cycle they must appear in;
// a monitor thread pops and compares whenever the DUT shows an event.
`timescale 1ns/1ps
module tb_sc_lane_scheduler;

    localparam int K_CLR   = 0;
    localparam int K_LOAD  = 1;
    localparam int K_SHIFT = 2;

    logic        clk    = 1'b0;
    logic        rst_n  = 1'b0;
    logic        startN = 1'b1;
    logic        tickN  = 1'b1;
    logic        pauseN = 1'b1;
    logic [15:0] speed  = 16'h0000;

    logic        clearN;
    logic        loadN;
    logic [3:0]  laneSel;
    logic [1:0]  shiftSel;
    logic        overrunN;

    typedef struct {
        int         kind;
        logic [3:0] sel;
        logic [1:0] sh;
        int         when;
    } ev_t;

    ev_t expQ[$];
    int  errors = 0;
    int  checks = 0;
    int  cyc    = 0;

    sc_lane_scheduler #(
        .LANES    (4),
        .SPEED_W  (4),
        .DIR_MASK (4'b0101)
    ) dut (
        .SC_LANE_SCHEDULER_CLOCK_50           (clk),
        .SC_LANE_SCHEDULER_RESET_InLow        (rst_n),
        .SC_LANE_SCHEDULER_startButton_InLow  (startN),
        .SC_LANE_SCHEDULER_tick_InLow         (tickN),
        .SC_LANE_SCHEDULER_pause_InLow        (pauseN),
        .SC_LANE_SCHEDULER_speed_In           (speed),
        .SC_LANE_SCHEDULER_clear_OutLow       (clearN),
        .SC_LANE_SCHEDULER_load_OutLow        (loadN),
        .SC_LANE_SCHEDULER_laneSelect_Out     (laneSel),
        .SC_LANE_SCHEDULER_shiftselection_Out (shiftSel),
        .SC_LANE_SCHEDULER_overrun_OutLow     (overrunN)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic void push_ev(input int kind, input logic [3:0] sel,
                                    input logic [1:0] sh, input int when);
        ev_t e;
        e.kind = kind;
        e.sel  = sel;
        e.sh   = sh;
        e.when = when;
        expQ.push_back(e);
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Start (or restart) from IDLE/RUN: clear pulse next cycle, load pulse the
    // one after, start released after three low samples, RUN entered at r.
    task automatic do_start(output int r);
        int c;
        c = cyc;
        startN = 1'b0;
        push_ev(K_CLR,  4'b0000, 2'b11, c + 1);
        push_ev(K_LOAD, 4'b0000, 2'b11, c + 2);
        step(3);
        startN = 1'b1;
        step(1);
        r = cyc;
    endtask

    initial begin
        int         r;
        logic [15:0] mask;

        fork
            begin : monitor
                int  kind;
                bit  seen;
                ev_t e;
                forever begin
                    @(negedge clk);
                    if (rst_n) begin
                        seen = 1'b0;
                        kind = 0;
                        if (!clearN) begin
                            kind = K_CLR;   seen = 1'b1;
                        end else if (!loadN) begin
                            kind = K_LOAD;  seen = 1'b1;
                        end else if (laneSel != 4'b0000 || shiftSel != 2'b11) begin
                            kind = K_SHIFT; seen = 1'b1;
                        end
                        if (seen) begin
                            checks++;
                            if (expQ.size() == 0) begin
                                errors++;
                                $display("FAIL unexpected_event: got kind=%0d sel=%b sh=%b cycle=%0d, expected no event",
                                         kind, laneSel, shiftSel, cyc);
                            end else begin
                                e = expQ.pop_front();
                                if (e.kind != kind || e.sel !== laneSel || e.sh !== shiftSel || e.when != cyc) begin
                                    errors++;
                                    $display("FAIL event: got kind=%0d sel=%b sh=%b cycle=%0d, expected kind=%0d sel=%b sh=%b cycle=%0d",
                                             kind, laneSel, shiftSel, cyc, e.kind, e.sel, e.sh, e.when);
                                end else begin
                                    $display("event kind=%0d sel=%b sh=%b cycle=%0d matched", kind, laneSel, shiftSel, cyc);
                                end
                            end
                        end
                    end
                end
            end
        join_none

        // ---------------- reset values ----------------
        speed = 16'h1111;
        step(3);
        chk("reset_clear",   {31'd0, clearN},   32'd0);
        chk("reset_load",    {31'd0, loadN},    32'd1);
        chk("reset_lanesel", {28'd0, laneSel},  32'd0);
        chk("reset_shift",   {30'd0, shiftSel}, 32'd3);
        chk("reset_overrun", {31'd0, overrunN}, 32'd1);
        push_ev(K_CLR, 4'b0000, 2'b11, cyc);
        rst_n = 1'b1;
        step(1);

        // ---------------- start timing + all lanes speed 1, single tick ----------------
        do_start(r);
        push_ev(K_SHIFT, 4'b0001, 2'b01, r + 2);
        push_ev(K_SHIFT, 4'b0010, 2'b10, r + 4);
        push_ev(K_SHIFT, 4'b0100, 2'b01, r + 6);
        push_ev(K_SHIFT, 4'b1000, 2'b10, r + 8);
        tickN = 1'b0;
        step(1);
        tickN = 1'b1;
        step(12);
        chk("drain_all_lanes", expQ.size(), 0);
        chk("overrun_all_lanes", {31'd0, overrunN}, 32'd1);

        // ---------------- lane0 speed 2, tick every 4th cycle, speed change ----------------
        speed = 16'h0002;
        do_start(r);
        mask = 16'h2554;   // shifts on ticks 2,4,6,8 (speed 2) then 10,13 (speed 3)
        for (int k = 1; k <= 14; k++) begin
            if (k == 9) speed = 16'h0003;
            tickN = 1'b0;
            step(1);
            if (mask[k]) push_ev(K_SHIFT, 4'b0001, 2'b01, cyc + 1);
            tickN = 1'b1;
            step(3);
        end
        step(4);
        chk("drain_lane0_rate", expQ.size(), 0);
        chk("overrun_lane0_rate", {31'd0, overrunN}, 32'd1);

        // ---------------- re-set coinciding with dispatch clear: no overrun ----------------
        speed = 16'h0200;
        do_start(r);
        push_ev(K_SHIFT, 4'b0100, 2'b01, r + 3);
        push_ev(K_SHIFT, 4'b0100, 2'b01, r + 5);
        push_ev(K_SHIFT, 4'b0100, 2'b01, r + 7);
        push_ev(K_SHIFT, 4'b0100, 2'b01, r + 9);
        tickN = 1'b0;
        step(8);
        tickN = 1'b1;
        step(5);
        chk("drain_coincident", expQ.size(), 0);
        chk("overrun_coincident", {31'd0, overrunN}, 32'd1);

        // ---------------- lane3 speed 1, tick held low: overrun ----------------
        speed = 16'h1000;
        do_start(r);
        for (int k = 2; k <= 10; k += 2) push_ev(K_SHIFT, 4'b1000, 2'b10, r + k);
        tickN = 1'b0;
        step(1);
        chk("overrun_first_set", {31'd0, overrunN}, 32'd1);
        step(1);
        chk("overrun_re_set", {31'd0, overrunN}, 32'd0);
        step(8);
        tickN = 1'b1;
        step(4);
        chk("overrun_sticky", {31'd0, overrunN}, 32'd0);
        chk("drain_overrun", expQ.size(), 0);

        // ---------------- restart clears overrun; reset during DISPATCH ----------------
        speed = 16'h0010;
        do_start(r);
        chk("overrun_cleared_by_init", {31'd0, overrunN}, 32'd1);
        tickN = 1'b0;
        step(1);
        tickN = 1'b1;
        step(1);
        chk("dispatch_lanesel", {28'd0, laneSel},  32'h2);
        chk("dispatch_shift",   {30'd0, shiftSel}, 32'h2);
        rst_n = 1'b0;
        #1;
        chk("abort_lanesel", {28'd0, laneSel},  32'd0);
        chk("abort_shift",   {30'd0, shiftSel}, 32'd3);
        chk("abort_clear",   {31'd0, clearN},   32'd0);
        chk("abort_load",    {31'd0, loadN},    32'd1);
        step(2);
        push_ev(K_CLR, 4'b0000, 2'b11, cyc);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tickN = k[0];
            step(1);
        end
        tickN = 1'b1;
        chk("drain_after_reset", expQ.size(), 0);

        // ---------------- pause window (ignored in default build) ----------------
        speed = 16'h0003;
        do_start(r);
`ifdef SC_LANE_SCHEDULER_PAUSE_EN
        mask = 16'h0900;   // ticks 2..6 frozen: shifts on ticks 8 and 11
`else
        mask = 16'h0248;   // pause ignored: shifts on ticks 3, 6 and 9
`endif
        for (int k = 1; k <= 11; k++) begin
            pauseN = (k >= 2 && k <= 6) ? 1'b0 : 1'b1;
            tickN = 1'b0;
            step(1);
            if (mask[k]) push_ev(K_SHIFT, 4'b0001, 2'b01, cyc + 1);
            tickN = 1'b1;
            step(1);
        end
        pauseN = 1'b1;
        step(4);
        chk("drain_pause", expQ.size(), 0);
        chk("overrun_pause", {31'd0, overrunN}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
